// File: rtl/ws2812_chain.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_chain
// Brief    : WS2812 daisy-chain driver with a 24-bit GRB pixel buffer and fill mode.
// Revision : 1.0 - initial release
// ============================================================================
module ws2812_chain #(
    parameter int NUM_LEDS = 8,
    parameter int AW       = 3,
    parameter int T0H      = 35,
    parameter int T1H      = 70,
    parameter int TBIT     = 125,
    parameter int TRESET   = 5000
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          i_Wr,
    input  logic [AW-1:0] i_WrAddr,
    input  logic [23:0]   i_WrData,
    input  logic          i_Start,
    input  logic          i_Fill,
    output logic          o_Ready,
    output logic          o_Done,
    output logic          o_Led
);

    localparam int            c_CNT_MAX   = (TBIT > TRESET) ? TBIT : TRESET;
    localparam int            CW          = $clog2(c_CNT_MAX + 1);
    localparam logic [CW-1:0] c_T0H_M1    = CW'(T0H - 1);
    localparam logic [CW-1:0] c_T1H_M1    = CW'(T1H - 1);
    localparam logic [CW-1:0] c_T0L_M1    = CW'(TBIT - T0H - 1);
    localparam logic [CW-1:0] c_T1L_M1    = CW'(TBIT - T1H - 1);
    localparam logic [CW-1:0] c_TRESET    = CW'(TRESET);
    localparam logic [CW-1:0] c_TRESET_M1 = CW'(TRESET - 1);
    localparam logic [AW-1:0] c_LAST_PIX  = AW'(NUM_LEDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_LATCH = 3'd4
    } state_t;

    state_t        r_state;
    logic [23:0]   r_mem [NUM_LEDS];
    logic [23:0]   r_shreg;
    logic [23:0]   r_pre;
    logic [23:0]   r_fill;
    logic          r_fill_mode;
    logic          r_frame;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_bit;
    logic [AW-1:0] r_pix;
    logic          r_ready;
    logic          r_done;
    logic          r_led;

    logic          w_addr_ok;
    logic [AW-1:0] w_next_pix;
    logic [23:0]   w_first;
    logic [23:0]   w_next;

    assign w_addr_ok  = (int'(i_WrAddr) < NUM_LEDS);
    assign w_next_pix = r_pix + AW'(1);
    assign w_first    = r_fill_mode ? r_fill : r_mem[0];
    assign w_next     = r_fill_mode ? r_fill : r_mem[w_next_pix];

    // Pixel buffer has no reset: contents survive Reset and are undefined at power-up.
    always_ff @(posedge Clock) begin
        if (i_Wr && w_addr_ok) begin
            r_mem[i_WrAddr] <= i_WrData;
        end
    end

    // o_Led is registered from the current state, so it trails the FSM by one clock;
    // the frame latch therefore spans TRESET+1 state cycles to keep TRESET low clocks on the pin.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_LATCH;
            r_cnt       <= c_TRESET_M1;
            r_bit       <= 5'd0;
            r_pix       <= '0;
            r_shreg     <= '0;
            r_pre       <= '0;
            r_fill      <= '0;
            r_fill_mode <= 1'b0;
            r_frame     <= 1'b0;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
            r_led       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_led  <= (r_state == S_HIGH);
            if (r_bit == 5'd0) begin
                r_pre <= w_next;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_Start && r_ready) begin
                        r_ready     <= 1'b0;
                        r_fill      <= i_WrData;
                        r_fill_mode <= i_Fill;
                        r_frame     <= 1'b1;
                        r_state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_shreg <= w_first;
                    r_bit   <= 5'd23;
                    r_pix   <= '0;
                    r_cnt   <= w_first[23] ? c_T1H_M1 : c_T0H_M1;
                    r_state <= S_HIGH;
                end
                S_HIGH: begin
                    if (r_cnt == '0) begin
                        r_cnt   <= r_shreg[23] ? c_T1L_M1 : c_T0L_M1;
                        r_state <= S_LOW;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_LOW: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_bit != 5'd0) begin
                        r_shreg <= {r_shreg[22:0], 1'b0};
                        r_bit   <= r_bit - 1'b1;
                        r_cnt   <= r_shreg[22] ? c_T1H_M1 : c_T0H_M1;
                        r_state <= S_HIGH;
                    end else if (r_pix != c_LAST_PIX) begin
                        r_shreg <= r_pre;
                        r_pix   <= w_next_pix;
                        r_bit   <= 5'd23;
                        r_cnt   <= r_pre[23] ? c_T1H_M1 : c_T0H_M1;
                        r_state <= S_HIGH;
                    end else begin
                        r_cnt   <= c_TRESET;
                        r_state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    if (r_cnt == '0) begin
                        r_ready <= 1'b1;
                        r_done  <= r_frame;
                        r_frame <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_LATCH;
                    r_cnt   <= c_TRESET_M1;
                end
            endcase
        end
    end

    assign o_Ready = r_ready;
    assign o_Done  = r_done;
    assign o_Led   = r_led;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_ws2812_chain
// Brief    : Self-checking bench for ws2812_chain with a waveform-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ws2812_chain;

    localparam int N      = 3;
    localparam int AW     = 2;
    localparam int T0H    = 2;
    localparam int T1H    = 5;
    localparam int TBIT   = 8;
    localparam int TRESET = 20;
    localparam int FBITS  = 24 * N;
    localparam int FRAME  = 2 + FBITS * TBIT + TRESET;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          i_Wr = 1'b0;
    logic [AW-1:0] i_WrAddr = '0;
    logic [23:0]   i_WrData = '0;
    logic          i_Start = 1'b0;
    logic          i_Fill = 1'b0;
    logic          o_Ready;
    logic          o_Done;
    logic          o_Led;

    ws2812_chain #(
        .NUM_LEDS(N), .AW(AW), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .i_Wr    (i_Wr),
        .i_WrAddr(i_WrAddr),
        .i_WrData(i_WrData),
        .i_Start (i_Start),
        .i_Fill  (i_Fill),
        .o_Ready (o_Ready),
        .o_Done  (o_Done),
        .o_Led   (o_Led)
    );

    always #5 Clock = ~Clock;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: frame position counted in clocks since the accept edge.
    typedef enum int {M_RST, M_POST, M_IDLE, M_FRAME} mode_t;
    mode_t       m_mode = M_RST;
    int          m_t = 0;
    logic        m_fill = 1'b0;
    logic        m_done = 1'b0;
    logic [23:0] m_buf [N];
    logic [23:0] m_pix [N];

    function automatic logic exp_led(input int t);
        logic [23:0] v;
        int k;
        if (t < 2 || t >= 2 + FBITS * TBIT) return 1'b0;
        k = (t - 2) / TBIT;
        v = m_pix[k / 24];
        return ((t - 2) % TBIT) < (v[23 - k % 24] ? T1H : T0H);
    endfunction

    always @(posedge Clock) begin : b_model
        m_done = 1'b0;
        if (i_Wr && int'(i_WrAddr) < N) m_buf[i_WrAddr] = i_WrData;
        if (Reset) begin
            m_mode = M_RST;
            m_t = 0;
        end else begin
            case (m_mode)
                M_RST: begin
                    m_mode = M_POST;
                    m_t = 1;
                end
                M_POST: begin
                    m_t++;
                    if (m_t >= TRESET) m_mode = M_IDLE;
                end
                M_IDLE: begin
                    if (i_Start) begin
                        m_mode = M_FRAME;
                        m_t = 0;
                        m_fill = i_Fill;
                        for (int p = 0; p < N; p++) m_pix[p] = i_Fill ? i_WrData : m_buf[p];
                    end
                end
                M_FRAME: begin
                    m_t++;
                    // a pixel takes whatever the buffer holds one bit before it starts
                    for (int p = 1; p < N; p++)
                        if (!m_fill && m_t == 2 + (24 * p - 1) * TBIT) m_pix[p] = m_buf[p];
                    if (m_t == FRAME) begin
                        m_mode = M_IDLE;
                        m_done = 1'b1;
                    end
                end
                default: m_mode = M_RST;
            endcase
        end
    end

    always @(negedge Clock) begin : b_chk
        logic el, er, ed;
        if (Reset || m_mode == M_RST) begin
            el = 1'b0; er = 1'b0; ed = 1'b0;
        end else begin
            el = (m_mode == M_FRAME) ? exp_led(m_t) : 1'b0;
            er = (m_mode == M_IDLE);
            ed = m_done;
        end
        chk("o_Led", 32'(o_Led), 32'(el));
        chk("o_Ready", 32'(o_Ready), 32'(er));
        chk("o_Done", 32'(o_Done), 32'(ed));
    end

    // Independent pulse-width decoder on the serial pin.
    logic [71:0] dec_bits = '0;
    int dec_n = 0, dec_bad = 0, hi_w = 0, done_cnt = 0;

    always @(negedge Clock) begin : b_dec
        if (o_Done) done_cnt++;
        if (o_Led) hi_w++;
        else if (hi_w > 0) begin
            if (hi_w == T1H) begin dec_bits = {dec_bits[70:0], 1'b1}; dec_n++; end
            else if (hi_w == T0H) begin dec_bits = {dec_bits[70:0], 1'b0}; dec_n++; end
            else dec_bad++;
            hi_w = 0;
        end
    end

    int since_acc = 0;

    task automatic cyc();
        @(posedge Clock);
        #1;
        since_acc++;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [23:0] d);
        i_Wr = 1'b1; i_WrAddr = a; i_WrData = d;
        cyc();
        i_Wr = 1'b0;
    endtask

    task automatic dec_clear();
        dec_bits = '0; dec_n = 0; dec_bad = 0; hi_w = 0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_Ready && n < 2 * FRAME) begin cyc(); n++; end
        if (!o_Ready) chk("ready_timeout", 32'(o_Ready), 32'd1);
    endtask

    task automatic start_frame(input logic fill, input logic [23:0] d, input logic hold);
        wait_ready();
        dec_clear();
        i_Start = 1'b1; i_Fill = fill; i_WrData = d;
        cyc();
        if (!hold) i_Start = 1'b0;
        i_Fill = 1'b0;
        since_acc = 0;
    endtask

    task automatic wait_done(input string name);
        while (!o_Done && since_acc < FRAME + 50) cyc();
        chk(name, 32'(since_acc), 32'(FRAME));
    endtask

    task automatic check_pixels(input string name, input logic [23:0] p0,
                                input logic [23:0] p1, input logic [23:0] p2);
        logic [71:0] b;
        b = dec_bits;
        chk({name, "_nbits"}, 32'(dec_n), 32'(FBITS));
        chk({name, "_badw"}, 32'(dec_bad), 32'd0);
        chk({name, "_px0"}, 32'(b[71:48]), 32'(p0));
        chk({name, "_px1"}, 32'(b[47:24]), 32'(p1));
        chk({name, "_px2"}, 32'(b[23:0]), 32'(p2));
    endtask

    initial begin : b_main
        int n;
        logic fill;
        logic [23:0] fd;
        logic [23:0] e0, e1, e2;

        // T1: reset and post-reset latch
        repeat (3) cyc();
        chk("t1_ready_in_reset", 32'(o_Ready), 32'd0);
        chk("t1_led_in_reset", 32'(o_Led), 32'd0);
        Reset = 1'b0;
        n = 0;
        while (!o_Ready && n < 100) begin cyc(); n++; end
        chk("t1_ready_delay", 32'(n), 32'd20);
        chk("t1_no_done", 32'(done_cnt), 32'd0);

        // T2: normal frame
        wr(2'd0, 24'hA50000);
        wr(2'd1, 24'h00FF00);
        wr(2'd2, 24'h000001);
        start_frame(1'b0, 24'h0, 1'b0);
        wait_done("t2_len");
        check_pixels("t2", 24'hA50000, 24'h00FF00, 24'h000001);

        // T3: fill frame leaves buffer intact
        start_frame(1'b1, 24'h123456, 1'b0);
        wait_done("t3_len");
        check_pixels("t3_fill", 24'h123456, 24'h123456, 24'h123456);
        start_frame(1'b0, 24'h0, 1'b0);
        wait_done("t3b_len");
        check_pixels("t3_after", 24'hA50000, 24'h00FF00, 24'h000001);

        // T4: writes during pixel 0
        start_frame(1'b0, 24'h0, 1'b0);
        while (since_acc < 30) cyc();
        wr(2'd2, 24'hFFFFFF);
        wr(2'd0, 24'h000000);
        wait_done("t4_len");
        check_pixels("t4_cur", 24'hA50000, 24'h00FF00, 24'hFFFFFF);
        start_frame(1'b0, 24'h0, 1'b0);
        wait_done("t4b_len");
        check_pixels("t4_next", 24'h000000, 24'h00FF00, 24'hFFFFFF);

        // T5: i_Start held through a frame, out-of-range write
        start_frame(1'b0, 24'h0, 1'b1);
        while (since_acc < 100) cyc();
        wr(2'd3, 24'hDEADBE);
        wait_done("t5a_len");
        check_pixels("t5a", 24'h000000, 24'h00FF00, 24'hFFFFFF);
        cyc();
        chk("t5_reaccept", 32'(o_Ready), 32'd0);
        since_acc = 0;
        dec_clear();
        repeat (50) cyc();
        i_Start = 1'b0;
        wait_done("t5b_len");
        check_pixels("t5b", 24'h000000, 24'h00FF00, 24'hFFFFFF);

        // T6: reset at bit 30
        start_frame(1'b0, 24'h0, 1'b0);
        while (since_acc < 2 + 30 * TBIT) cyc();
        chk("t6_led_high", 32'(o_Led), 32'd1);
        Reset = 1'b1;
        #1;
        chk("t6_led_async", 32'(o_Led), 32'd0);
        cyc(); cyc();
        Reset = 1'b0;
        n = 0;
        while (!o_Ready && n < 100) begin cyc(); n++; end
        chk("t6_ready_delay", 32'(n), 32'd20);
        start_frame(1'b0, 24'h0, 1'b0);
        wait_done("t6_len");
        check_pixels("t6", 24'h000000, 24'h00FF00, 24'hFFFFFF);

        // Randomized frames
        for (int it = 0; it < 6; it++) begin
            n = int'($urandom_range(1, 4));
            for (int w = 0; w < n; w++) wr(AW'($urandom_range(0, 3)), 24'($urandom));
            repeat ($urandom_range(0, 5)) cyc();
            fill = ($urandom_range(0, 2) == 0);
            fd = 24'($urandom);
            e0 = fill ? fd : m_buf[0];
            e1 = fill ? fd : m_buf[1];
            e2 = fill ? fd : m_buf[2];
            start_frame(fill, fd, 1'b0);
            wait_done("rnd_len");
            check_pixels("rnd", e0, e1, e2);
        end

        repeat (5) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : b_watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
